mul_operand_sequencer: RTL and testbench

//  Upstream feeder for the repeated-addition multiplier (datapath + controller).

---
 rtl/mul_operand_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mul_operand_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_sequencer.sv
// Feeds a repeated-addition multiplier from a 2-deep operand queue: start pulse,
// then A, then B on the shared bus; returns the product (or a watchdog abort).
module mul_operand_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 65535,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_data,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    OUT    = 3'd5
  } state_e;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q;
  logic [WIDTH-1:0] fifo_a_q [2];
  logic [WIDTH-1:0] fifo_b_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WD_W-1:0]  wd_q;
  logic             done_q;
  logic             mul_start_q;
  logic [WIDTH-1:0] mul_data_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_err_q;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_zero;
  logic             head_swap;

  assign op_ready  = (count_q != 2'd2);
  assign push      = op_valid & op_ready;
  assign pop       = (state_q == IDLE) && (count_q != 2'd0);
  assign head_a    = fifo_a_q[rd_ptr_q];
  assign head_b    = fifo_b_q[rd_ptr_q];
  assign head_zero = (head_a == '0) || (head_b == '0);
  assign head_swap = SWAP_EN && (head_b > head_a);

  // NOTE: queue storage has no reset; count_q/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= op_a;
      fifo_b_q[wr_ptr_q] <= op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      wd_q        <= '0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      done_q      <= mul_done;
      mul_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            if (head_zero) begin
              res_data_q  <= '0;
              res_err_q   <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= OUT;
            end else begin
              a_q         <= head_swap ? head_b : head_a;
              b_q         <= head_swap ? head_a : head_b;
              mul_start_q <= 1'b1;
              mul_data_q  <= '0;
              state_q     <= START;
            end
          end
        end
        START: begin
          mul_data_q <= a_q;
          state_q    <= LOAD_A;
        end
        LOAD_A: begin
          mul_data_q <= b_q;
          state_q    <= LOAD_B;
        end
        LOAD_B: begin
          wd_q    <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Only a fresh rising edge of done counts; a level left over is ignored.
          if (mul_done && !done_q) begin
            res_data_q  <= mul_y;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
            res_data_q  <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_start = mul_start_q;
  assign mul_data  = mul_data_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer: a behavioural multiplier answers the load
// sequence; expected operand orders and results are queued at operand accept.
module tb_mul_operand_sequencer;

  localparam int W  = 32;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         mul_start;
  logic [W-1:0] mul_data;
  logic         mul_done = 1'b0;
  logic [W-1:0] mul_y = '0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_err;
  logic         busy;

  mul_operand_sequencer #(.WIDTH(W), .TIMEOUT(TO), .SWAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done), .mul_y(mul_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } res_t;

  res_t           exp_res [$];
  logic [2*W-1:0] exp_ops [$];

  // Behavioural multiplier: sees start, latches A then B, answers after a few cycles.
  bit           hang = 1'b0;
  int           start_cnt = 0;
  int           m_phase = 0;
  int           m_wait = 0;
  logic [W-1:0] m_a, m_b;
  logic [2*W-1:0] m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase  = 0;
      mul_done = 1'b0;
    end else if (mul_start) begin
      start_cnt++;
      n_vec++;
      if (mul_data !== '0) begin
        n_bad++;
        $display("FAIL start_bus: mul_data=%0d during start, expected 0", mul_data);
      end
      mul_done = 1'b0;
      m_phase  = 1;
    end else begin
      case (m_phase)
        1: begin
          m_a     = mul_data;
          m_phase = 2;
        end
        2: begin
          m_b     = mul_data;
          m_phase = 3;
          m_wait  = (m_b > 8) ? 10 : int'(m_b) + 2;
          n_vec++;
          if (exp_ops.size() == 0) begin
            n_bad++;
            $display("FAIL operand_order: unexpected load A=%0d B=%0d", m_a, m_b);
          end else begin
            m_exp = exp_ops.pop_front();
            if ({m_a, m_b} !== m_exp) begin
              n_bad++;
              $display("FAIL operand_order: got A=%0d B=%0d, expected A=%0d B=%0d",
                       m_a, m_b, m_exp[2*W-1:W], m_exp[W-1:0]);
            end
          end
        end
        3: begin
          if (!hang) begin
            m_wait--;
            if (m_wait == 0) begin
              mul_y    = m_a * m_b;
              mul_done = 1'b1;
              m_phase  = 0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Result scoreboard: one pop per completed res_valid/res_ready handshake.
  res_t r_exp;
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      n_vec++;
      if (exp_res.size() == 0) begin
        n_bad++;
        $display("FAIL result: unexpected result data=%0d err=%b", res_data, res_err);
      end else begin
        r_exp = exp_res.pop_front();
        if ({res_data, res_err} !== r_exp) begin
          n_bad++;
          $display("FAIL result: got data=%0d err=%b, expected data=%0d err=%b",
                   res_data, res_err, r_exp.data, r_exp.err);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit abort);
    int           guard = 0;
    logic [W-1:0] sa, sb, prod;
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    @(negedge clk);
    while (!op_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!op_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL op_accept: op_ready=%b after %0d cycles, expected 1", op_ready, guard);
      op_valid = 1'b0;
      return;
    end
    if (a == '0 || b == '0) begin
      exp_res.push_back('{data: '0, err: 1'b0});
    end else begin
      sa   = (b > a) ? b : a;
      sb   = (b > a) ? a : b;
      prod = a * b;
      exp_ops.push_back({sa, sb});
      exp_res.push_back(abort ? '{data: '0, err: 1'b1} : '{data: prod, err: 1'b0});
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int g = 0;
    while ((exp_res.size() != 0 || busy) && g < limit) begin
      @(negedge clk);
      g++;
    end
    n_vec++;
    if (exp_res.size() != 0 || busy) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding busy=%b after %0d cycles, expected 0",
               exp_res.size(), busy, g);
      exp_res.delete();
      exp_ops.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Negedges from now until sig-high, capped; returns limit+1 on expiry.
  task automatic count_until_start(input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mul_start && lat <= limit);
  endtask

  task automatic count_until_valid(input int limit, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat <= limit);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, res_valid, res_err, mul_start, op_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL reset_flags: busy,res_valid,res_err,mul_start,op_ready=%b expected 00001",
               {busy, res_valid, res_err, mul_start, op_ready});
    end
    n_vec++;
    if (res_data !== '0 || mul_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data: res_data=%0d mul_data=%0d expected 0 0", res_data, mul_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || op_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy=%b op_ready=%b expected 0 1", busy, op_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat;
    send(32'd8020, 32'd9, 1'b0);
    count_until_start(10, lat);
    n_vec++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL start_latency: mul_start seen %0d negedges after accept, expected 2", lat);
    end
    wait_drain(100);
  endtask

  task automatic test_swap();
    send(32'd9, 32'd8020, 1'b0);
    wait_drain(100);
  endtask

  task automatic test_zero_bypass();
    int s = start_cnt;
    int lat;
    send(32'd0, 32'd5, 1'b0);
    count_until_valid(10, lat);
    n_vec++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL bypass_latency: res_valid seen %0d negedges after accept, expected 2", lat);
    end
    @(posedge clk);
    #1;
    send(32'd7, 32'd0, 1'b0);
    wait_drain(50);
    n_vec++;
    if (start_cnt !== s) begin
      n_bad++;
      $display("FAIL bypass_no_start: %0d start pulses, expected 0", start_cnt - s);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    res_ready = 1'b0;
    send(32'd3, 32'd4, 1'b0);
    send(32'd5, 32'd6, 1'b0);
    send(32'd2, 32'd2, 1'b0);
    @(negedge clk);
    n_vec++;
    if (op_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL queue_full: op_ready=%b with two queued, expected 0", op_ready);
    end
    count_until_valid(60, lat);
    repeat (3) @(negedge clk);
    n_vec++;
    if (res_valid !== 1'b1 || res_data !== 32'd12 || op_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL out_hold: res_valid=%b res_data=%0d op_ready=%b expected 1 12 0",
               res_valid, res_data, op_ready);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_drain(200);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, t;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = W'($urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) begin
        t = a;
        a = b;
        b = t;
      end
      send(a, b, 1'b0);
    end
    wait_drain(400);
  endtask

  task automatic test_timeout();
    int lat;
    hang = 1'b1;
    send(32'd6, 32'd7, 1'b1);
    count_until_start(10, lat);
    count_until_valid(60, lat);
    n_vec++;
    if (lat !== 3 + TO) begin
      n_bad++;
      $display("FAIL timeout_cycles: res_valid %0d negedges after start, expected %0d", lat, 3 + TO);
    end
    wait_drain(20);
    hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    int s;
    hang = 1'b1;
    send(32'd11, 32'd13, 1'b0);
    send(32'd21, 32'd2, 1'b0);
    count_until_start(10, lat);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_res.delete();
    exp_ops.delete();
    hang = 1'b0;
    s = start_cnt;
    @(negedge clk);
    n_vec++;
    if ({busy, res_valid, op_ready, mul_start} !== 4'b0010) begin
      n_bad++;
      $display("FAIL reset_mid: busy,res_valid,op_ready,mul_start=%b expected 0010",
               {busy, res_valid, op_ready, mul_start});
    end
    repeat (10) @(negedge clk);
    n_vec++;
    if (start_cnt !== s || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL queue_flush: %0d starts busy=%b after reset, expected 0 0",
               start_cnt - s, busy);
    end
    @(posedge clk);
    #1;
    send(32'd4, 32'd5, 1'b0);
    wait_drain(100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_zero_bypass();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "time limit");
  end

endmodule
